// File: rtl/text_pack_ctrl.sv
// Text transmit front-end: maps 8-bit characters to 7-bit symbols and packs
// them LSB-first into a byte stream, with end-of-message padding and tagging.
module text_pack_ctrl #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [7:0]       OUT_DATA,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             DONE,
  output logic [ERR_W-1:0] ERR_CNT
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [14:0]      acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [7:0] d_off;
  logic [6:0] sym;
  logic       sym_valid;
  logic       slot_free;
  logic       accept;

  always_comb begin
    d_off     = IN_DATA - 8'd32;
    sym       = '0;
    sym_valid = 1'b1;
    case (d_off)
      8'd130:  sym = 7'd95;
      8'd131:  sym = 7'd97;
      8'd133:  sym = 7'd109;
      8'd137:  sym = 7'd111;
      8'd142:  sym = 7'd112;
      8'd144:  sym = 7'd125;
      default: begin
        if (d_off <= 8'd94) sym = d_off[6:0];
        else                sym_valid = 1'b0;
      end
    endcase
  end

  assign IN_READY  = (state_q == RUN) && (cnt_q < 4'd8);
  assign accept    = IN_VALID && IN_READY;
  assign slot_free = !out_valid_q || OUT_READY;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !OUT_READY;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (sym_valid) begin
            acc_d = acc_q | (15'(sym) << cnt_q);
            cnt_d = cnt_q + 4'd7;
          end else if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
          if (IN_LAST) state_d = FLUSH;
        end else if (cnt_q >= 4'd8 && slot_free) begin
          out_data_d  = acc_q[7:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          acc_d       = acc_q >> 8;
          cnt_d       = cnt_q - 4'd8;
        end
      end
      default: begin
        if (slot_free && cnt_q >= 4'd8) begin
          out_data_d  = acc_q[7:0];
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == 4'd8);
          acc_d       = acc_q >> 8;
          cnt_d       = cnt_q - 4'd8;
        end else if (slot_free && cnt_q != 4'd0) begin
          // bits above CNT in ACC are always zero, so this is the zero-padded tail
          out_data_d  = acc_q[7:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else if (cnt_q == 4'd0 && !(out_valid_q && out_last_q && !OUT_READY)) begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign DONE      = done_q;
  assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_text_pack_ctrl.sv
// Directed bench for text_pack_ctrl; expected bytes are hand-packed symbol streams.
module tb_text_pack_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IN_DATA = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_LAST = 1'b0;
  logic       IN_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_LAST;
  logic       OUT_READY = 1'b0;
  logic       DONE;
  logic [7:0] ERR_CNT;

  logic [7:0] IN_DATA2 = '0;
  logic       IN_VALID2 = 1'b0;
  logic       IN_READY2;
  logic [7:0] OUT_DATA2;
  logic       OUT_VALID2;
  logic       OUT_LAST2;
  logic       DONE2;
  logic [1:0] ERR_CNT2;

  always #5 CLK = ~CLK;

  text_pack_ctrl #(.ERR_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY),
    .DONE(DONE), .ERR_CNT(ERR_CNT)
  );

  text_pack_ctrl #(.ERR_W(2)) dut2 (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA2), .IN_VALID(IN_VALID2), .IN_LAST(1'b0), .IN_READY(IN_READY2),
    .OUT_DATA(OUT_DATA2), .OUT_VALID(OUT_VALID2), .OUT_LAST(OUT_LAST2), .OUT_READY(1'b1),
    .DONE(DONE2), .ERR_CNT(ERR_CNT2)
  );

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  q[$];
  int unsigned done_n = 0;
  int unsigned done_base = 0;
  int          rd = 0;

  // Byte monitor: records {last, data} on every output handshake.
  always @(posedge CLK) begin
    if (OUT_VALID && OUT_READY) q.push_back({OUT_LAST, OUT_DATA});
    if (DONE) done_n <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic l);
    int unsigned n;
    n = 0;
    IN_DATA  = c;
    IN_LAST  = l;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("accept_wait_timeout", 32'(n), 32'd0);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic begin_msg();
    rd        = q.size();
    done_base = done_n;
  endtask

  task automatic chk_byte(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = (rd < q.size()) ? q[rd] : 9'bx;
    rd++;
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic end_msg(input string tag);
    chk({tag, "_extra_bytes"}, 32'(q.size() - rd), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_n - done_base), 32'd1);
  endtask

  task automatic settle();
    repeat (12) @(negedge CLK);
  endtask

  initial begin
    // reset state
    @(negedge CLK);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_data",  32'(OUT_DATA),  32'd0);
    chk("rst_out_last",  32'(OUT_LAST),  32'd0);
    chk("rst_done",      32'(DONE),      32'd0);
    chk("rst_err_cnt",   32'(ERR_CNT),   32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready",  32'(IN_READY),  32'd1);
    OUT_READY = 1'b1;

    // 'A','B' -> 0x21, 0x11(last)
    begin_msg();
    send(8'd65, 1'b0);
    send(8'd66, 1'b1);
    settle();
    chk_byte("ab_b0", 9'h021);
    chk_byte("ab_b1", 9'h111);
    end_msg("ab");
    chk("ab_err_cnt", 32'(ERR_CNT), 32'd0);

    // special characters
    begin_msg();
    send(8'd162, 1'b1);
    settle();
    chk_byte("cent", 9'h15F);
    end_msg("cent");
    begin_msg();
    send(8'd163, 1'b1);
    settle();
    chk_byte("euro", 9'h161);
    end_msg("euro");
    begin_msg();
    send(8'd176, 1'b1);
    settle();
    chk_byte("degree", 9'h17D);
    end_msg("degree");

    // eight spaces -> seven zero bytes, last on the seventh
    begin_msg();
    for (int i = 0; i < 8; i++) send(8'd32, (i == 7));
    settle();
    for (int i = 0; i < 6; i++) chk_byte("space_mid", 9'h000);
    chk_byte("space_last", 9'h100);
    end_msg("space");

    // invalid characters dropped and counted
    begin_msg();
    send(8'd10, 1'b0);
    send(8'd127, 1'b0);
    send(8'd200, 1'b0);
    send(8'd67, 1'b1);
    settle();
    chk_byte("inv_c", 9'h123);
    end_msg("inv");
    chk("inv_err_cnt", 32'(ERR_CNT), 32'd3);

    // message of only an invalid character: no byte, DONE still pulses
    begin_msg();
    send(8'd5, 1'b1);
    settle();
    end_msg("empty");
    chk("empty_err_cnt", 32'(ERR_CNT), 32'd4);

    // backpressure: 8 x 'A' packs to A1 50 28 14 0A 85 42
    begin_msg();
    OUT_READY = 1'b0;
    send(8'd65, 1'b0);
    send(8'd65, 1'b0);
    send(8'd65, 1'b0);
    IN_DATA  = 8'd65;
    IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_in_ready",  32'(IN_READY),  32'd0);
      chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_out_data",  32'(OUT_DATA),  32'hA1);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 3; i < 8; i++) send(8'd65, (i == 7));
    settle();
    chk_byte("bp_b0", 9'h0A1);
    chk_byte("bp_b1", 9'h050);
    chk_byte("bp_b2", 9'h028);
    chk_byte("bp_b3", 9'h014);
    chk_byte("bp_b4", 9'h00A);
    chk_byte("bp_b5", 9'h085);
    chk_byte("bp_b6", 9'h142);
    end_msg("bp");

    // reset during FLUSH with a byte pending
    OUT_READY = 1'b0;
    send(8'd65, 1'b0);
    send(8'd66, 1'b1);
    repeat (3) @(negedge CLK);
    chk("mf_pending_valid", 32'(OUT_VALID), 32'd1);
    chk("mf_in_ready",      32'(IN_READY),  32'd0);
    RST = 1'b1;
    #1;
    chk("mf_rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("mf_rst_out_data",  32'(OUT_DATA),  32'd0);
    chk("mf_rst_out_last",  32'(OUT_LAST),  32'd0);
    chk("mf_rst_done",      32'(DONE),      32'd0);
    chk("mf_rst_err_cnt",   32'(ERR_CNT),   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    OUT_READY = 1'b1;
    begin_msg();
    send(8'd65, 1'b1);
    settle();
    chk_byte("mf_a", 9'h121);
    end_msg("mf");

    // ERR_W = 2 saturates at 3
    IN_DATA2  = 8'd0;
    IN_VALID2 = 1'b1;
    repeat (2) @(negedge CLK);
    chk("sat_two", 32'(ERR_CNT2), 32'd2);
    repeat (3) @(negedge CLK);
    IN_VALID2 = 1'b0;
    @(negedge CLK);
    chk("sat_hold", 32'(ERR_CNT2), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
